// File: rtl/canny_pkg.sv
// Shared types and constants for the Canny NMS frame controller.
// FSM states, edge-flag codes and sticky error bit positions.
package canny_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        FRAME    = 2'd2
    } state_t;

    localparam logic [1:0] EDGE_NONE   = 2'd0;
    localparam logic [1:0] EDGE_WEAK   = 2'd1;
    localparam logic [1:0] EDGE_STRONG = 2'd2;

    localparam int ERR_SHORT = 0;
    localparam int ERR_LONG  = 1;
    localparam int ERR_OVR   = 2;

endpackage

// File: rtl/canny_pos_counter.sv
// Row/column tracker for the NMS output stream: border flag, line-length checks, EOF.
// Ports: clk/rst, en (in FRAME), beat sideband, geometry; border/short/long/eof out.
module canny_pos_counter
    import canny_pkg::*;
#(
    parameter int DIM_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             tvalid,
    input  logic             tuser,
    input  logic             tlast,
    input  logic [DIM_W-1:0] width,
    input  logic [DIM_W-1:0] height,
    output logic             border,
    output logic             short_err,
    output logic             long_err,
    output logic             eof
);

    logic [DIM_W-1:0] row;
    logic [DIM_W-1:0] col;
    logic [DIM_W-1:0] row_cur;
    logic [DIM_W-1:0] col_cur;
    logic [DIM_W-1:0] row_max;
    logic [DIM_W-1:0] col_max;
    logic             beat;

    assign row_max = height - DIM_W'(1);
    assign col_max = width - DIM_W'(1);

    // SOF beat is always position (0,0), whatever the counters held
    assign row_cur = tuser ? '0 : row;
    assign col_cur = tuser ? '0 : col;
    assign beat    = en & tvalid;

    assign border    = (row_cur == '0) | (row_cur == row_max) |
                       (col_cur == '0) | (col_cur == col_max);
    assign short_err = beat & tlast & (col_cur < col_max);
    assign long_err  = beat & ~tlast & (col_cur == col_max);
    assign eof       = beat & tlast & (row_cur == row_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (eof) begin
            row <= '0;
            col <= '0;
        end else if (beat) begin
            if (tlast) begin
                col <= '0;
                row <= row_cur + DIM_W'(1);
            end else begin
                // overlong lines park on the last column until tlast
                col <= (col_cur >= col_max) ? col_cur : col_cur + DIM_W'(1);
                row <= row_cur;
            end
        end
    end

endmodule

// File: rtl/canny_nms_frame_ctrl.sv
// Frame sequencer for Canny NMS: commits config at SOF, masks border, checks geometry.
// Ports: cfg_* in, nms_* config out, nms stream in, m_axis_* out, sts_* status.
module canny_nms_frame_ctrl
    import canny_pkg::*;
#(
    parameter int DIM_W = 12,
    parameter int CNT_W = 16
) (
    input  logic             s_axis_aclk,
    input  logic             s_axis_areset,
    input  logic             cfg_run,
    input  logic             cfg_enable,
    input  logic [7:0]       cfg_maxVal,
    input  logic [7:0]       cfg_minVal,
    input  logic [DIM_W-1:0] cfg_width,
    input  logic [DIM_W-1:0] cfg_height,
    input  logic             sts_clear,
    input  logic             in_tvalid,
    input  logic             in_tuser,
    output logic             nms_enable,
    output logic [7:0]       nms_maxVal,
    output logic [7:0]       nms_minVal,
    input  logic             nms_tvalid,
    input  logic             nms_tuser,
    input  logic             nms_tlast,
    input  logic [1:0]       nms_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tuser,
    output logic             m_axis_tlast,
    output logic [1:0]       m_axis_tdata,
    output logic             sts_busy,
    output logic             sts_frame_done,
    output logic [CNT_W-1:0] sts_frame_cnt,
    output logic [2:0]       sts_err
);

    state_t     state;
    state_t     state_nxt;
    logic       frame;
    logic       sof_in;
    logic       commit;
    logic       ovr;
    logic       border;
    logic       short_err;
    logic       long_err;
    logic       eof;
    logic       beat;
    logic [2:0] err_set;

    assign frame  = (state == FRAME);
    assign sof_in = in_tvalid & in_tuser;
    assign beat   = frame & nms_tvalid;

    canny_pos_counter #(.DIM_W(DIM_W)) u_pos (
        .clk       (s_axis_aclk),
        .rst       (s_axis_areset),
        .en        (frame),
        .tvalid    (nms_tvalid),
        .tuser     (nms_tuser),
        .tlast     (nms_tlast),
        .width     (cfg_width),
        .height    (cfg_height),
        .border    (border),
        .short_err (short_err),
        .long_err  (long_err),
        .eof       (eof)
    );

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) state <= IDLE;
        else               state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        ovr       = 1'b0;
        unique case (state)
            IDLE: begin
                if (cfg_run) state_nxt = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (!cfg_run) begin
                    state_nxt = IDLE;
                end else if (sof_in) begin
                    state_nxt = FRAME;
                    commit    = 1'b1;
                end
            end
            FRAME: begin
                if (eof) begin
                    // back-to-back frames: old one ends, new one starts
                    if (sof_in) commit = 1'b1;
                    else state_nxt = cfg_run ? WAIT_SOF : IDLE;
                end else if (sof_in) begin
                    ovr = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        err_set            = '0;
        err_set[ERR_SHORT] = short_err;
        err_set[ERR_LONG]  = long_err;
        err_set[ERR_OVR]   = ovr;
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            nms_enable     <= 1'b0;
            nms_maxVal     <= '0;
            nms_minVal     <= '0;
            m_axis_tvalid  <= 1'b0;
            m_axis_tuser   <= 1'b0;
            m_axis_tlast   <= 1'b0;
            m_axis_tdata   <= EDGE_NONE;
            sts_frame_done <= 1'b0;
            sts_frame_cnt  <= '0;
            sts_err        <= '0;
        end else begin
            if (commit) begin
                nms_enable <= cfg_enable;
                nms_maxVal <= cfg_maxVal;
                nms_minVal <= cfg_minVal;
            end
            m_axis_tvalid  <= beat;
            m_axis_tuser   <= beat & nms_tuser;
            m_axis_tlast   <= beat & nms_tlast;
            m_axis_tdata   <= (beat && !border) ? nms_tdata : EDGE_NONE;
            sts_frame_done <= eof;
            if (eof) sts_frame_cnt <= sts_frame_cnt + CNT_W'(1);
            // a new error beats a same-cycle clear
            sts_err <= (sts_clear ? 3'b000 : sts_err) | err_set;
        end
    end

    assign sts_busy = frame;

endmodule

// File: tb/tb_canny_nms_frame_ctrl.sv
// Directed bench for canny_nms_frame_ctrl with a queue-based expected-beat model.
// Inputs change at negedge+1; outputs are compared on each negedge.
module tb_canny_nms_frame_ctrl;

    localparam int DIM_W = 12;
    localparam int CNT_W = 16;
    localparam int W = 5;
    localparam int H = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_run;
    logic             cfg_enable;
    logic [7:0]       cfg_maxVal;
    logic [7:0]       cfg_minVal;
    logic [DIM_W-1:0] cfg_width;
    logic [DIM_W-1:0] cfg_height;
    logic             sts_clear;
    logic             in_tvalid;
    logic             in_tuser;
    logic             nms_enable;
    logic [7:0]       nms_maxVal;
    logic [7:0]       nms_minVal;
    logic             nms_tvalid;
    logic             nms_tuser;
    logic             nms_tlast;
    logic [1:0]       nms_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tuser;
    logic             m_axis_tlast;
    logic [1:0]       m_axis_tdata;
    logic             sts_busy;
    logic             sts_frame_done;
    logic [CNT_W-1:0] sts_frame_cnt;
    logic [2:0]       sts_err;

    canny_nms_frame_ctrl #(.DIM_W(DIM_W), .CNT_W(CNT_W)) dut (
        .s_axis_aclk    (clk),
        .s_axis_areset  (rst),
        .cfg_run        (cfg_run),
        .cfg_enable     (cfg_enable),
        .cfg_maxVal     (cfg_maxVal),
        .cfg_minVal     (cfg_minVal),
        .cfg_width      (cfg_width),
        .cfg_height     (cfg_height),
        .sts_clear      (sts_clear),
        .in_tvalid      (in_tvalid),
        .in_tuser       (in_tuser),
        .nms_enable     (nms_enable),
        .nms_maxVal     (nms_maxVal),
        .nms_minVal     (nms_minVal),
        .nms_tvalid     (nms_tvalid),
        .nms_tuser      (nms_tuser),
        .nms_tlast      (nms_tlast),
        .nms_tdata      (nms_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tdata   (m_axis_tdata),
        .sts_busy       (sts_busy),
        .sts_frame_done (sts_frame_done),
        .sts_frame_cnt  (sts_frame_cnt),
        .sts_err        (sts_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       u;
        logic       l;
        logic [1:0] d;
        logic       done;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          n_vec = 0;
    int          n_bad = 0;
    int          n_done_seen = 0;
    int          n_two_seen = 0;
    logic [15:0] m_cnt = '0;
    logic        exp_done;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // compare process: every output beat is matched against the model queue
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_cnt = '0;
            chk("rst_tvalid", 32'(m_axis_tvalid), 0);
            chk("rst_done", 32'(sts_frame_done), 0);
            chk("rst_cnt", 32'(sts_frame_cnt), 0);
            chk("rst_err", 32'(sts_err), 0);
            chk("rst_busy", 32'(sts_busy), 0);
            chk("rst_maxval", 32'(nms_maxVal), 0);
            chk("rst_enable", 32'(nms_enable), 0);
        end else begin
            exp_done = 1'b0;
            if (m_axis_tvalid) begin
                chk("beat_expected", 32'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("tuser", 32'(m_axis_tuser), 32'(e.u));
                    chk("tlast", 32'(m_axis_tlast), 32'(e.l));
                    chk("tdata", 32'(m_axis_tdata), 32'(e.d));
                    exp_done = e.done;
                    if (e.done) m_cnt = m_cnt + 16'd1;
                end
                if (m_axis_tdata == 2'd2) n_two_seen++;
            end
            chk("frame_done", 32'(sts_frame_done), 32'(exp_done));
            chk("frame_cnt", 32'(sts_frame_cnt), 32'(m_cnt));
            if (sts_frame_done) n_done_seen++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic in_sof();
        in_tvalid = 1'b1;
        in_tuser  = 1'b1;
        tick();
        in_tvalid = 1'b0;
        in_tuser  = 1'b0;
    endtask

    // one NMS output beat at line position c of row r, line length nb
    task automatic beat(input int r, input int c, input int nb,
                        input logic sof, input logic [1:0] d);
        int   col;
        logic bord;
        exp_t x;
        col  = (c > W - 1) ? W - 1 : c;
        bord = (r == 0) || (r == H - 1) || (col == 0) || (col == W - 1);
        x.u    = (r == 0 && c == 0);
        x.l    = (c == nb - 1);
        x.d    = bord ? 2'd0 : d;
        x.done = x.l && (r == H - 1);
        q.push_back(x);
        nms_tvalid = 1'b1;
        nms_tuser  = x.u;
        nms_tlast  = x.l;
        nms_tdata  = d;
        in_tvalid  = sof;
        in_tuser   = sof;
        tick();
        nms_tvalid = 1'b0;
        nms_tuser  = 1'b0;
        nms_tlast  = 1'b0;
        nms_tdata  = 2'd0;
        in_tvalid  = 1'b0;
        in_tuser   = 1'b0;
    endtask

    task automatic line(input int r, input int nb, input logic [1:0] d);
        for (int c = 0; c < nb; c++) beat(r, c, nb, 1'b0, d);
    endtask

    task automatic clear_err();
        sts_clear = 1'b1;
        tick();
        sts_clear = 1'b0;
        chk("err_cleared", 32'(sts_err), 0);
    endtask

    initial begin
        rst = 1'b1;
        cfg_run = 1'b0;
        cfg_enable = 1'b1;
        cfg_maxVal = 8'd40;
        cfg_minVal = 8'd20;
        cfg_width = DIM_W'(W);
        cfg_height = DIM_W'(H);
        sts_clear = 1'b0;
        in_tvalid = 1'b0;
        in_tuser = 1'b0;
        nms_tvalid = 1'b0;
        nms_tuser = 1'b0;
        nms_tlast = 1'b0;
        nms_tdata = 2'd0;
        tick();
        tick();
        rst = 1'b0;

        // frame 1: all-strong input, border masked, maxVal changes mid-frame
        cfg_run = 1'b1;
        tick();
        in_sof();
        chk("f1_busy", 32'(sts_busy), 1);
        chk("f1_max", 32'(nms_maxVal), 40);
        chk("f1_min", 32'(nms_minVal), 20);
        chk("f1_en", 32'(nms_enable), 1);
        line(0, W, 2'd2);
        cfg_maxVal = 8'd90;
        line(1, W, 2'd2);
        chk("f1_max_held", 32'(nms_maxVal), 40);
        line(2, W, 2'd2);
        line(3, W, 2'd2);
        tick();
        chk("f1_two_cnt", 32'(n_two_seen), 6);
        chk("f1_done_cnt", 32'(n_done_seen), 1);
        chk("f1_frame_cnt", 32'(sts_frame_cnt), 1);
        chk("f1_idle_busy", 32'(sts_busy), 0);
        chk("f1_drained", 32'(q.size()), 0);
        chk("f2_max_pre", 32'(nms_maxVal), 40);

        // frame 2: SOF overrun in row 2
        in_sof();
        chk("f2_max", 32'(nms_maxVal), 90);
        line(0, W, 2'd1);
        line(1, W, 2'd1);
        cfg_maxVal = 8'd120;
        beat(2, 0, W, 1'b1, 2'd1);
        chk("f2_ovr", 32'(sts_err), 3'b100);
        chk("f2_max_kept", 32'(nms_maxVal), 90);
        chk("f2_busy", 32'(sts_busy), 1);
        for (int c = 1; c < W; c++) beat(2, c, W, 1'b0, 2'd1);
        line(3, W, 2'd1);
        tick();
        chk("f2_frame_cnt", 32'(sts_frame_cnt), 2);
        clear_err();

        // frame 3: short line
        in_sof();
        chk("f3_max", 32'(nms_maxVal), 120);
        line(0, W, 2'd2);
        line(1, 3, 2'd2);
        chk("f3_short", 32'(sts_err), 3'b001);
        line(2, W, 2'd1);
        line(3, W, 2'd1);
        tick();
        chk("f3_drained", 32'(q.size()), 0);
        clear_err();

        // frame 4: seven-beat line
        in_sof();
        line(0, W, 2'd1);
        for (int c = 0; c < 7; c++) begin
            beat(1, c, 7, 1'b0, 2'd2);
            if (c == 3) chk("f4_no_long_yet", 32'(sts_err), 0);
            if (c == 4) chk("f4_long", 32'(sts_err), 3'b010);
        end
        line(2, W, 2'd2);
        line(3, W, 2'd2);
        tick();
        chk("f4_frame_cnt", 32'(sts_frame_cnt), 4);
        clear_err();

        // frame 5 ends with the next SOF in the same cycle
        in_sof();
        line(0, W, 2'd2);
        line(1, W, 2'd1);
        line(2, W, 2'd2);
        cfg_maxVal = 8'd77;
        for (int c = 0; c < W - 1; c++) beat(3, c, W, 1'b0, 2'd1);
        beat(3, W - 1, W, 1'b1, 2'd1);
        chk("f5_busy", 32'(sts_busy), 1);
        chk("f5_no_ovr", 32'(sts_err), 0);
        chk("f5_max", 32'(nms_maxVal), 77);

        // frame 6: run dropped mid-frame
        line(0, W, 2'd2);
        cfg_run = 1'b0;
        line(1, W, 2'd2);
        line(2, W, 2'd1);
        line(3, W, 2'd2);
        tick();
        chk("f6_frame_cnt", 32'(sts_frame_cnt), 6);
        chk("f6_idle", 32'(sts_busy), 0);
        cfg_maxVal = 8'd11;
        in_sof();
        chk("f6_idle_sof", 32'(sts_busy), 0);
        chk("f6_no_commit", 32'(nms_maxVal), 77);

        // frame 7: reset mid-frame
        cfg_run = 1'b1;
        tick();
        in_sof();
        line(0, W, 2'd2);
        line(1, W, 2'd2);
        beat(2, 0, W, 1'b0, 2'd2);
        beat(2, 1, W, 1'b0, 2'd2);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(m_axis_tvalid), 0);
        chk("mid_rst_done", 32'(sts_frame_done), 0);
        chk("mid_rst_cnt", 32'(sts_frame_cnt), 0);
        chk("mid_rst_busy", 32'(sts_busy), 0);
        rst = 1'b0;
        cfg_run = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
